// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types, constants and helper functions for the
//                fetch/data memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Response FSM: which port, if any, is owed a response this cycle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } state_e;

    // Port that won the most recent grant; drives the round-robin tie-break.
    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } gnt_e;

    // Legal data-port lane enables.
    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    // True when the lane enables are illegal or do not match the byte offset.
    function automatic logic be_misaligned(input logic [3:0] be, input logic [1:0] lo);
        logic bad;
        case (be)
            BE_B0:   bad = (lo != 2'd0);
            BE_B1:   bad = (lo != 2'd1);
            BE_B2:   bad = (lo != 2'd2);
            BE_B3:   bad = (lo != 2'd3);
            BE_H0:   bad = (lo != 2'd0);
            BE_H1:   bad = (lo != 2'd2);
            BE_W:    bad = (lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // True when any byte-address bit above the memory's byte space is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int addr_w);
        return (addr >> (addr_w + 2)) != 32'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_load_formatter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_load_formatter
//  Description : Combinational load lane extraction: selects the addressed
//                byte/halfword/word, right-aligns it and sign/zero extends.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_load_formatter
    import mem_port_arbiter_pkg::*;
(
    input  logic [3:0]  be_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        is_signed_i,
    input  logic [31:0] word_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        ext;

    // Shift the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        shifted = word_i >> {addr_lo_i, 3'b000};
        ext     = 1'b0;
        rdata_o = shifted;
        case (be_i)
            BE_W: begin
                rdata_o = shifted;
            end
            BE_H0, BE_H1: begin
                ext     = is_signed_i & shifted[15];
                rdata_o = {{16{ext}}, shifted[15:0]};
            end
            default: begin
                ext     = is_signed_i & shifted[7];
                rdata_o = {{24{ext}}, shifted[7:0]};
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port synchronous memory (1-cycle read
//                latency) between instruction-fetch and data ports with
//                round-robin arbitration, range/alignment checking and load
//                lane formatting.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 14,
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    // Fetch port
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_rdata_o,
    output logic              if_valid_o,
    output logic              if_err_o,
    // Data port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic              d_is_signed_i,
    input  logic [31:0]       d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic [31:0]       d_rdata_o,
    output logic              d_valid_o,
    output logic              d_err_o,
    // Memory macro
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    state_e      state_q, state_d;
    gnt_e        last_gnt_q, last_gnt_d;

    // Context of the access in flight, consumed in the response cycle.
    logic        err_q, err_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  lo_q, lo_d;
    logic        signed_q, signed_d;

    logic        if_elig, d_elig;
    logic        if_err_now, d_err_now;
    logic        issue_i, issue_d;
    logic [31:0] fmt_rdata;

    // A port cannot reissue while its own response is on the bus; issue is
    // also held off while reset is asserted so the memory sees no strobe.
    assign if_elig    = resetb_i & if_req_i & (state_q != ST_RESP_I);
    assign d_elig     = resetb_i & d_req_i  & (state_q != ST_RESP_D);

    assign if_err_now = addr_out_of_range(if_addr_i, ADDR_W) | (if_addr_i[1:0] != 2'd0);
    assign d_err_now  = addr_out_of_range(d_addr_i, ADDR_W) | be_misaligned(d_be_i, d_addr_i[1:0]);

    assign mem_wdata_o = d_wdata_i;

    // Arbitration, next state, captured context and memory strobes.
    always_comb begin
        issue_i    = 1'b0;
        issue_d    = 1'b0;
        state_d    = ST_IDLE;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        we_d       = we_q;
        be_d       = be_q;
        lo_d       = lo_q;
        signed_d   = signed_q;
        mem_en_o   = 1'b0;
        mem_we_o   = 1'b0;
        mem_be_o   = 4'b0000;
        mem_addr_o = d_addr_i[ADDR_W+1:2];

        if (if_elig && d_elig) begin
            if (last_gnt_q == GNT_DATA) begin
                issue_i = 1'b1;
            end else begin
                issue_d = 1'b1;
            end
        end else begin
            issue_i = if_elig;
            issue_d = d_elig;
        end

        if (issue_i) begin
            state_d    = ST_RESP_I;
            last_gnt_d = GNT_FETCH;
            err_d      = if_err_now;
            we_d       = 1'b0;
            mem_en_o   = ~if_err_now;
            mem_addr_o = if_addr_i[ADDR_W+1:2];
        end else if (issue_d) begin
            state_d    = ST_RESP_D;
            last_gnt_d = GNT_DATA;
            err_d      = d_err_now;
            we_d       = d_we_i;
            be_d       = d_be_i;
            lo_d       = d_addr_i[1:0];
            signed_d   = d_is_signed_i;
            mem_en_o   = ~d_err_now;
            mem_we_o   = ~d_err_now & d_we_i;
            mem_be_o   = (~d_err_now & d_we_i) ? d_be_i : 4'b0000;
            mem_addr_o = d_addr_i[ADDR_W+1:2];
        end
    end

    // State, grant history and response context; reset drops any pending response.
    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= DATA_FIRST ? GNT_FETCH : GNT_DATA;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'b0000;
            lo_q       <= 2'b00;
            signed_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
            we_q       <= we_d;
            be_q       <= be_d;
            lo_q       <= lo_d;
            signed_q   <= signed_d;
        end
    end

    mem_port_arbiter_load_formatter u_fmt (
        .be_i        (be_q),
        .addr_lo_i   (lo_q),
        .is_signed_i (signed_q),
        .word_i      (mem_rdata_i),
        .rdata_o     (fmt_rdata)
    );

    assign if_valid_o = (state_q == ST_RESP_I);
    assign if_err_o   = if_valid_o & err_q;
    assign if_rdata_o = err_q ? 32'd0 : mem_rdata_i;

    assign d_valid_o  = (state_q == ST_RESP_D);
    assign d_err_o    = d_valid_o & err_q;
    assign d_rdata_o  = (err_q | we_q) ? 32'd0 : fmt_rdata;

    // Requesters must hold req until their response has been returned.
    a_if_req_held: assert property (@(posedge clk_i) disable iff (!resetb_i)
        (state_q == ST_RESP_I) |-> if_req_i);
    a_d_req_held: assert property (@(posedge clk_i) disable iff (!resetb_i)
        (state_q == ST_RESP_D) |-> d_req_i);

endmodule
`default_nettype wire
